// File: rtl/pll_sup_pkg.sv
// Shared types and constants for the PLL lock supervisor.
// Holds the FSM state encoding, default parameters and the timer-width helper.
package pll_sup_pkg;

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    STABILIZE = 2'd2,
    RUN       = 2'd3
  } pll_sup_state_t;

  localparam int unsigned DEF_SYNC_STAGES    = 2;
  localparam int unsigned DEF_PLL_RST_CYCLES = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT   = 50000;
  localparam int unsigned DEF_STABLE_CYCLES  = 1024;

  localparam logic [7:0] EVT_CNT_MAX = 8'hFF;

  // The timer only ever needs to reach (largest interval - 1).
  function automatic int unsigned cnt_width(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// PLL-side and downstream-side signals of the lock supervisor.
// master = supervisor, slave = PLL wrapper / consumers.
interface pll_lock_supervisor_if;
  logic       locked_async;
  logic       relock_req;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic [7:0] relock_count;
  logic [7:0] timeout_count;

  modport master (
    input  locked_async,
    input  relock_req,
    output pll_rst,
    output sys_rst,
    output ready,
    output relock_count,
    output timeout_count
  );

  modport slave (
    output locked_async,
    output relock_req,
    input  pll_rst,
    input  sys_rst,
    input  ready,
    input  relock_count,
    input  timeout_count
  );
endinterface

// File: rtl/sync_bit.sv
// N-stage single-bit synchroniser with synchronous reset to RESET_VAL.
// STAGES must be at least 2.
module sync_bit #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) begin
      ff <= {STAGES{RESET_VAL}};
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences the PLL reset, qualifies lock over a stability window and releases sys_rst/ready.
// Re-resets the PLL on lock timeout, lock loss or request; keeps saturating debug counters.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES
) (
  input  logic                  refclk,
  input  logic                  rst,
  pll_lock_supervisor_if.master bus
);

  localparam int unsigned CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

  localparam logic [CW-1:0] RST_LAST  = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STAB_LAST = CW'(STABLE_CYCLES - 1);

  logic locked_s;

  sync_bit #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b0)
  ) u_lock_sync (
    .clk(refclk),
    .rst(rst),
    .d  (bus.locked_async),
    .q  (locked_s)
  );

  pll_sup_state_t state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [7:0]     relock_q, relock_d;
  logic [7:0]     timeout_q, timeout_d;
  logic           pll_rst_q, sys_rst_q, ready_q;
  logic           relock_evt, timeout_evt;

  always_comb begin
    state_d     = state_q;
    relock_evt  = 1'b0;
    timeout_evt = 1'b0;

    // A request outranks lock loss, so a coincident loss still counts once.
    if (bus.relock_req && (state_q != PLL_RESET)) begin
      state_d    = PLL_RESET;
      relock_evt = 1'b1;
    end else begin
      unique case (state_q)
        PLL_RESET: begin
          if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_d = STABILIZE;
          end else if (cnt_q == TO_LAST) begin
            state_d     = PLL_RESET;
            timeout_evt = 1'b1;
          end
        end
        STABILIZE: begin
          if (!locked_s) begin
            state_d = WAIT_LOCK;
          end else if (cnt_q == STAB_LAST) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (!locked_s) begin
            state_d    = PLL_RESET;
            relock_evt = 1'b1;
          end
        end
        default: state_d = PLL_RESET;
      endcase
    end

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == RUN) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    relock_d  = (relock_evt && (relock_q != EVT_CNT_MAX)) ? relock_q + 8'd1 : relock_q;
    timeout_d = (timeout_evt && (timeout_q != EVT_CNT_MAX)) ? timeout_q + 8'd1 : timeout_q;
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= PLL_RESET;
      cnt_q     <= '0;
      relock_q  <= '0;
      timeout_q <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      relock_q  <= relock_d;
      timeout_q <= timeout_d;
      // Decoded from the next state so outputs move with the state register.
      pll_rst_q <= (state_d == PLL_RESET);
      sys_rst_q <= (state_d != RUN);
      ready_q   <= (state_d == RUN);
    end
  end

  assign bus.pll_rst       = pll_rst_q;
  assign bus.sys_rst       = sys_rst_q;
  assign bus.ready         = ready_q;
  assign bus.relock_count  = relock_q;
  assign bus.timeout_count = timeout_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed, table-driven bench for pll_lock_supervisor with short bench parameters.
// Each row: inputs driven before an edge, outputs expected just after it.
module tb_pll_lock_supervisor;

  logic clk = 1'b0;
  logic rst;

  pll_lock_supervisor_if bus ();

  pll_lock_supervisor #(
    .SYNC_STAGES   (2),
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8)
  ) dut (
    .refclk(clk),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       lk;
    logic       rq;
    logic       prst;
    logic       srst;
    logic       rdy;
    logic [7:0] rc;
    logic [7:0] tc;
    string      tag;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   split_idx;
  int   rises, last_rise, period_err, rdy_seen, model_tc, got_fall;
  logic prev_prst;

  task automatic add(input int n, input logic r, input logic l, input logic q, input logic p,
                     input logic s, input logic y, input int rc, input int tc, input string tag);
    vec_t v;
    v.rst = r; v.lk = l; v.rq = q;
    v.prst = p; v.srst = s; v.rdy = y;
    v.rc = 8'(rc); v.tc = 8'(tc); v.tag = tag;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic run_vecs(input int lo, input int hi);
    logic [18:0] act, exp;
    for (int i = lo; i < hi; i++) begin
      rst              = vecs[i].rst;
      bus.locked_async = vecs[i].lk;
      bus.relock_req   = vecs[i].rq;
      step();
      act = {bus.pll_rst, bus.sys_rst, bus.ready, bus.relock_count, bus.timeout_count};
      exp = {vecs[i].prst, vecs[i].srst, vecs[i].rdy, vecs[i].rc, vecs[i].tc};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL %s[%0d]: got pll_rst/sys_rst/ready=%b rc=%0d tc=%0d expected %b rc=%0d tc=%0d",
                 vecs[i].tag, i, act[18:16], act[15:8], act[7:0], exp[18:16], exp[15:8],
                 exp[7:0]);
      end
    end
  endtask

  initial begin
    rst              = 1'b1;
    bus.locked_async = 1'b0;
    bus.relock_req   = 1'b0;

    // Part A: reset, lock, loss, glitch, requests, two timeouts.
    //   n  rst lk rq  prst srst rdy rc tc
    add(2,  1, 0, 0,  1, 1, 0, 0, 0, "reset");
    add(3,  0, 0, 0,  1, 1, 0, 0, 0, "pll_rst_pulse");
    add(7,  0, 0, 0,  0, 1, 0, 0, 0, "wait_lock");
    add(10, 0, 1, 0,  0, 1, 0, 0, 0, "stabilize");
    add(5,  0, 1, 0,  0, 0, 1, 0, 0, "run");
    add(2,  0, 0, 0,  0, 0, 1, 0, 0, "loss_sync");
    add(2,  0, 0, 0,  1, 1, 0, 1, 0, "loss_reset");
    add(2,  0, 1, 0,  1, 1, 0, 1, 0, "loss_reset_lk");
    add(6,  0, 1, 0,  0, 1, 0, 1, 0, "relock_stab");
    add(2,  0, 0, 0,  0, 1, 0, 1, 0, "glitch");
    add(10, 0, 1, 0,  0, 1, 0, 1, 0, "restab");
    add(3,  0, 1, 0,  0, 0, 1, 1, 0, "run2");
    add(2,  0, 0, 0,  0, 0, 1, 1, 0, "loss2_sync");
    add(1,  0, 0, 1,  1, 1, 0, 2, 0, "req_and_loss");
    add(1,  0, 0, 1,  1, 1, 0, 2, 0, "req_in_reset");
    add(1,  0, 0, 0,  1, 1, 0, 2, 0, "pll_reset");
    add(1,  0, 0, 1,  1, 1, 0, 2, 0, "req_in_reset_last");
    add(20, 0, 0, 0,  0, 1, 0, 2, 0, "timeout_wait");
    add(4,  0, 0, 0,  1, 1, 0, 2, 1, "timeout1");
    add(20, 0, 0, 0,  0, 1, 0, 2, 1, "timeout_wait2");
    add(4,  0, 0, 0,  1, 1, 0, 2, 2, "timeout2");
    split_idx = vecs.size();

    // Part B: starts right after a timeout pulse ends (WAIT_LOCK, timer 0).
    add(2,  0, 1, 0,  0, 1, 0, 2, 255, "sat_wait");
    add(3,  0, 1, 0,  0, 1, 0, 2, 255, "sat_stab");
    add(1,  1, 1, 0,  1, 1, 0, 0, 0,   "rst_mid_stab");
    add(3,  0, 1, 0,  1, 1, 0, 0, 0,   "post_rst_pulse");
    add(9,  0, 1, 0,  0, 1, 0, 0, 0,   "post_rst_lock");
    add(3,  0, 1, 0,  0, 0, 1, 0, 0,   "post_rst_run");
    add(1,  0, 1, 1,  1, 1, 0, 1, 0,   "req_run");
    add(3,  0, 1, 0,  1, 1, 0, 1, 0,   "req_run_pulse");
    add(1,  0, 1, 0,  0, 1, 0, 1, 0,   "req_run_done");

    run_vecs(0, split_idx);

    // Saturation: 258 further timeouts on top of the two already counted.
    rst              = 1'b0;
    bus.locked_async = 1'b0;
    bus.relock_req   = 1'b0;
    prev_prst  = bus.pll_rst;
    rises      = 0;
    last_rise  = -1;
    period_err = 0;
    rdy_seen   = 0;
    model_tc   = 2;
    for (int cyc = 0; cyc < 7000 && rises < 258; cyc++) begin
      step();
      if (bus.ready) rdy_seen++;
      if (bus.pll_rst && !prev_prst) begin
        rises++;
        if (model_tc < 255) model_tc++;
        if (last_rise >= 0 && (cyc - last_rise) != 24) period_err++;
        last_rise = cyc;
      end
      prev_prst = bus.pll_rst;
    end
    check("sat_rises", 32'(rises), 32'd258);
    check("sat_period", 32'(period_err), 32'd0);
    check("sat_ready_never", 32'(rdy_seen), 32'd0);
    check("sat_timeout_count", 32'(bus.timeout_count), 32'(model_tc));

    got_fall = 0;
    for (int k = 0; k < 8 && got_fall == 0; k++) begin
      step();
      if (!bus.pll_rst) got_fall = 1;
    end
    check("sat_pulse_end", 32'(got_fall), 32'd1);

    run_vecs(split_idx, vecs.size());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
